// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// M-stage memory access controller for the pipelined MIPS core.
//
// It takes one load/store from the M stage and checks the address alignment.
// It then builds the byte enables and the lane-replicated store data, and runs
// a single req/ack transaction with the bridge/DM. The pipeline is stalled
// until the transaction finishes. For a load, the controller then hands the
// raw read word, addr[1:0] and the load-extension op to the data-extension
// stage that follows.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid         M-stage instruction performs a memory access
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10/11 word
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   req_ldop          load-extension op, passed through to rsp_op
//   req_kill          exception flush of the M-stage instruction
//   stall             freeze F/D/E/M
//   exc_adel/exc_ades misaligned load / store (combinational, IDLE only)
//   bus_req/bus_we    transaction request (held until ack) / write flag
//   bus_addr          word-aligned address
//   bus_byteen        written byte lanes, 0000 for loads
//   bus_wdata         lane-replicated store data
//   bus_ack/bus_rdata bridge completion, read word valid with ack
//   rsp_valid         one-cycle load-data-ready pulse
//   rsp_rdata         captured read word
//   rsp_addr_lo       latched addr[1:0]
//   rsp_op            latched req_ldop
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_ldop,
  input  logic              req_kill,
  output logic              stall,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_byteen,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_addr_lo,
  output logic [2:0]        rsp_op
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        discard;

  logic        is_word;
  logic        is_half;
  logic        misaligned;
  logic        can_issue;
  logic        accept;
  logic [3:0]  next_byteen;
  logic [31:0] next_wdata;

  // Request decode: alignment check, accept, exceptions and the stall.
  // Exceptions are raised only for a live, unkilled request seen in IDLE, so
  // they can never overlap a stall. The stall is high in the accept cycle,
  // before any state changes, so the M-stage instruction is held from the
  // first cycle. In RESP the stall drops and the instruction moves on.
  always_comb begin
    is_word    = req_size[1];
    is_half    = (req_size == 2'b01);
    misaligned = (is_half && req_addr[0]) ||
                 (is_word && (req_addr[1:0] != 2'b00));
    can_issue  = (state == IDLE) && req_valid && !req_kill;
    accept     = can_issue && !misaligned;
    exc_adel   = can_issue && misaligned && !req_we;
    exc_ades   = can_issue && misaligned && req_we;
    stall      = accept || (state == BUSY);
    // A kill that arrives in RESP itself must still suppress the pulse, so
    // this output stays combinational rather than registered.
    rsp_valid  = (state == RESP) && !bus_we && !discard && !req_kill;
  end

  // Lane steering for the request being accepted. Store data is replicated
  // across every lane, so the byte enables alone select what the DM writes.
  // Loads write nothing.
  always_comb begin
    next_byteen = 4'b0000;
    next_wdata  = req_wdata;
    if (is_word) begin
      next_wdata = req_wdata;
    end else if (is_half) begin
      next_wdata = {2{req_wdata[15:0]}};
    end else begin
      next_wdata = {4{req_wdata[7:0]}};
    end
    if (req_we) begin
      if (is_word) begin
        next_byteen = 4'b1111;
      end else if (is_half) begin
        next_byteen = req_addr[1] ? 4'b1100 : 4'b0011;
      end else begin
        next_byteen = 4'b0001 << req_addr[1:0];
      end
    end
  end

  // Transaction FSM with registered bus and response outputs.
  // All bus_* values are captured once, on accept. This keeps them stable for
  // the whole of BUSY, whatever the M stage does with its inputs.
  // The discard flag remembers a kill seen while the bus is busy. The
  // transaction itself cannot be aborted, so only the response is dropped.
  // Reset is synchronous. A reset in BUSY releases bus_req on the next edge,
  // and any ack that arrives later is ignored because bus_req is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      discard     <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_byteen  <= 4'b0000;
      bus_wdata   <= 32'd0;
      rsp_rdata   <= 32'd0;
      rsp_addr_lo <= 2'b00;
      rsp_op      <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (accept) begin
            bus_req     <= 1'b1;
            bus_we      <= req_we;
            bus_addr    <= {req_addr[ADDR_W-1:2], 2'b00};
            bus_byteen  <= next_byteen;
            bus_wdata   <= next_wdata;
            rsp_addr_lo <= req_addr[1:0];
            rsp_op      <= req_ldop;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (req_kill) begin
            discard <= 1'b1;
          end
          if (bus_req && bus_ack) begin
            rsp_rdata <= bus_rdata;
            bus_req   <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          // Clear the discard flag on the way back to IDLE.
          discard <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          discard <= 1'b0;
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed testbench for mem_access_ctrl. Each applyStimulus call moves the
// bench forward one clock cycle. It drives the inputs just after the rising
// edge and then returns at the falling edge, where checkOutput samples the
// DUT. Every expected value below is worked out by hand from the intended
// behaviour of the controller.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ldop;
  logic        req_kill;
  logic        stall;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_addr_lo;
  logic [2:0]  rsp_op;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ldop   (req_ldop),
    .req_kill   (req_kill),
    .stall      (stall),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_byteen (bus_byteen),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_addr_lo(rsp_addr_lo),
    .rsp_op     (rsp_op)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run one cycle: drive all inputs just after the rising edge, then return
  // at the falling edge so the outputs can be sampled mid-cycle.
  task automatic applyStimulus(input logic rst, input logic v, input logic we,
                               input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] ldop,
                               input logic kill, input logic ack,
                               input logic [31:0] rdata);
    @(posedge clk);
    #1;
    reset     = rst;
    req_valid = v;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_ldop  = ldop;
    req_kill  = kill;
    bus_ack   = ack;
    bus_rdata = rdata;
    @(negedge clk);
  endtask

  // One comparison: count it, and on a mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = SZ_B;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_ldop  = 3'b000;
    req_kill  = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;

    // Reset state.
    applyStimulus(1, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("rst_bus_req", bus_req, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_byteen", bus_byteen, 4'h0);

    $display("[TB] lw 0x00001004, ack in cycle 1");
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_1004, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("lw_c0_stall", stall, 1);
    checkOutput("lw_c0_bus_req", bus_req, 0);
    checkOutput("lw_c0_exc_adel", exc_adel, 0);
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_1004, 32'h0, 3'b000, 0, 1, 32'h8899_AABB);
    checkOutput("lw_c1_bus_req", bus_req, 1);
    checkOutput("lw_c1_bus_addr", bus_addr, 32'h0000_1004);
    checkOutput("lw_c1_byteen", bus_byteen, 4'b0000);
    checkOutput("lw_c1_bus_we", bus_we, 0);
    checkOutput("lw_c1_stall", stall, 1);
    checkOutput("lw_c1_rsp_valid", rsp_valid, 0);
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_1004, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("lw_c2_rsp_valid", rsp_valid, 1);
    checkOutput("lw_c2_rsp_rdata", rsp_rdata, 32'h8899_AABB);
    checkOutput("lw_c2_addr_lo", rsp_addr_lo, 2'b00);
    checkOutput("lw_c2_rsp_op", rsp_op, 3'b000);
    checkOutput("lw_c2_stall", stall, 0);
    checkOutput("lw_c2_bus_req", bus_req, 0);
    applyStimulus(0, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("lw_c3_rsp_valid", rsp_valid, 0);
    checkOutput("lw_c3_stall", stall, 0);
    checkOutput("lw_c3_rdata_hold", rsp_rdata, 32'h8899_AABB);

    $display("[TB] sb 0x00002003 then sh 0x00002002");
    applyStimulus(0, 1, 1, SZ_B, 32'h0000_2003, 32'h1234_56CD, 3'b000, 0, 0, 32'h0);
    checkOutput("sb_c0_stall", stall, 1);
    applyStimulus(0, 1, 1, SZ_B, 32'h0000_2003, 32'h1234_56CD, 3'b000, 0, 1, 32'h0);
    checkOutput("sb_bus_we", bus_we, 1);
    checkOutput("sb_byteen", bus_byteen, 4'b1000);
    checkOutput("sb_wdata", bus_wdata, 32'hCDCD_CDCD);
    checkOutput("sb_bus_addr", bus_addr, 32'h0000_2000);
    applyStimulus(0, 1, 1, SZ_B, 32'h0000_2003, 32'h1234_56CD, 3'b000, 0, 0, 32'h0);
    checkOutput("sb_rsp_valid", rsp_valid, 0);
    checkOutput("sb_resp_stall", stall, 0);
    applyStimulus(0, 1, 1, SZ_H, 32'h0000_2002, 32'h0000_BEEF, 3'b000, 0, 0, 32'h0);
    checkOutput("sh_c0_stall", stall, 1);
    applyStimulus(0, 1, 1, SZ_H, 32'h0000_2002, 32'h0000_BEEF, 3'b000, 0, 1, 32'h0);
    checkOutput("sh_byteen", bus_byteen, 4'b1100);
    checkOutput("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    applyStimulus(0, 1, 1, SZ_H, 32'h0000_2002, 32'h0000_BEEF, 3'b000, 0, 0, 32'h0);
    checkOutput("sh_rsp_valid", rsp_valid, 0);

    $display("[TB] misaligned lh / sw, killed misaligned lh");
    applyStimulus(0, 1, 0, SZ_H, 32'h0000_0001, 32'h0, 3'b100, 0, 0, 32'h0);
    checkOutput("lh_mis_exc_adel", exc_adel, 1);
    checkOutput("lh_mis_exc_ades", exc_ades, 0);
    checkOutput("lh_mis_stall", stall, 0);
    applyStimulus(0, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("lh_mis_bus_req", bus_req, 0);
    applyStimulus(0, 1, 1, SZ_W, 32'h0000_0002, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("sw_mis_exc_ades", exc_ades, 1);
    checkOutput("sw_mis_exc_adel", exc_adel, 0);
    checkOutput("sw_mis_stall", stall, 0);
    applyStimulus(0, 1, 0, SZ_H, 32'h0000_0001, 32'h0, 3'b100, 1, 0, 32'h0);
    checkOutput("kill_mis_exc_adel", exc_adel, 0);
    checkOutput("kill_stall", stall, 0);
    applyStimulus(0, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("kill_bus_req", bus_req, 0);

    // lb at 0x6 with a 5-cycle ack delay. While BUSY the request inputs are
    // scrambled, and the bus outputs must not follow them.
    $display("[TB] lb 0x00000006, ack delayed 5 cycles");
    stall_cnt = 0;
    applyStimulus(0, 1, 0, SZ_B, 32'h0000_0006, 32'h0, 3'b010, 0, 0, 32'h0);
    stall_cnt += int'(stall);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 0, SZ_H, 32'h0000_0F01 + 32'(i * 16), 32'hFFFF_FFFF,
                    3'b111, 0, (i == 5), (i == 5) ? 32'h00F0_0000 : 32'hDEAD_0000);
      stall_cnt += int'(stall);
      checkOutput($sformatf("lb_busy%0d_bus_req", i), bus_req, 1);
      checkOutput($sformatf("lb_busy%0d_bus_addr", i), bus_addr, 32'h0000_0004);
      checkOutput($sformatf("lb_busy%0d_byteen", i), bus_byteen, 4'b0000);
      checkOutput($sformatf("lb_busy%0d_exc_adel", i), exc_adel, 0);
    end
    applyStimulus(0, 1, 0, SZ_B, 32'h0000_0006, 32'h0, 3'b010, 0, 0, 32'h0);
    stall_cnt += int'(stall);
    checkOutput("lb_rsp_valid", rsp_valid, 1);
    checkOutput("lb_rsp_rdata", rsp_rdata, 32'h00F0_0000);
    checkOutput("lb_addr_lo", rsp_addr_lo, 2'b10);
    checkOutput("lb_rsp_op", rsp_op, 3'b010);
    checkOutput("lb_stall_cycles", 32'(stall_cnt), 32'd6);
    // A stray ack in IDLE must not disturb anything.
    applyStimulus(0, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 1, 32'hDEAD_BEEF);
    checkOutput("idle_ack_rsp_valid", rsp_valid, 0);
    checkOutput("idle_ack_stall", stall, 0);
    applyStimulus(0, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("idle_ack_rdata_hold", rsp_rdata, 32'h00F0_0000);
    checkOutput("idle_ack_bus_req", bus_req, 0);

    $display("[TB] lw killed in second BUSY cycle");
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_3000, 32'h0, 3'b000, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_3000, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("kbusy_c1_stall", stall, 1);
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_3000, 32'h0, 3'b000, 1, 0, 32'h0);
    checkOutput("kbusy_c2_stall", stall, 1);
    checkOutput("kbusy_c2_bus_req", bus_req, 1);
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_3000, 32'h0, 3'b000, 0, 1, 32'h1122_3344);
    checkOutput("kbusy_c3_stall", stall, 1);
    checkOutput("kbusy_c3_bus_req", bus_req, 1);
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_3000, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("kbusy_rsp_valid", rsp_valid, 0);
    checkOutput("kbusy_resp_stall", stall, 0);
    checkOutput("kbusy_rsp_rdata", rsp_rdata, 32'h1122_3344);

    $display("[TB] kill in RESP, then clean load");
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_0010, 32'h0, 3'b000, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_0010, 32'h0, 3'b000, 0, 1, 32'h5A5A_5A5A);
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_0010, 32'h0, 3'b000, 1, 0, 32'h0);
    checkOutput("kresp_rsp_valid", rsp_valid, 0);
    applyStimulus(0, 1, 0, SZ_H, 32'h0000_0042, 32'h0, 3'b011, 0, 0, 32'h0);
    checkOutput("clean_c0_stall", stall, 1);
    applyStimulus(0, 1, 0, SZ_H, 32'h0000_0042, 32'h0, 3'b011, 0, 1, 32'hA5A5_A5A5);
    checkOutput("clean_bus_addr", bus_addr, 32'h0000_0040);
    applyStimulus(0, 1, 0, SZ_H, 32'h0000_0042, 32'h0, 3'b011, 0, 0, 32'h0);
    checkOutput("clean_rsp_valid", rsp_valid, 1);
    checkOutput("clean_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
    checkOutput("clean_addr_lo", rsp_addr_lo, 2'b10);
    checkOutput("clean_rsp_op", rsp_op, 3'b011);

    $display("[TB] reset during BUSY, late ack");
    applyStimulus(0, 1, 0, SZ_W, 32'h0000_5000, 32'h0, 3'b000, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, SZ_W, 32'h0000_5000, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("rbusy_bus_req_before", bus_req, 1);
    applyStimulus(0, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 1, 32'hCAFE_F00D);
    checkOutput("rbusy_bus_req", bus_req, 0);
    checkOutput("rbusy_stall", stall, 0);
    checkOutput("rbusy_rsp_valid", rsp_valid, 0);
    applyStimulus(0, 0, 0, SZ_B, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
    checkOutput("rbusy_late_rsp_valid", rsp_valid, 0);
    checkOutput("rbusy_late_stall", stall, 0);
    checkOutput("rbusy_late_rdata", rsp_rdata, 32'h0);
    checkOutput("rbusy_late_bus_req", bus_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
